spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl_pkg.sv | 21 ++
 rtl/spi_sclk_gen.sv | 39 +++
 rtl/spi_master_ctrl.sv | 118 +++++++++++
 tb/tb_spi_master_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_ctrl_pkg.sv
// Shared constants, frame field widths and FSM encoding for the SPI master controller.
package spi_master_ctrl_pkg;

  localparam int MASTER_FRAME_WIDTH = 24;
  localparam int CMD_BITS           = 8;
  localparam int ADDR_BITS          = 8;
  localparam int PAYLOAD_BITS       = 8;
  localparam int DEFAULT_CLK_DIV    = 2;
  localparam int BIT_CNT_W          = 5;

  localparam logic [CMD_BITS-1:0] CMD_LED_SET = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter and mode-0 clock toggling, with one-cycle
// strobes marking the sysclk edge on which sclk rises or falls.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic sysclk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] half_cnt;
  logic             half_end;

  assign half_end = run && (half_cnt == CNT_W'(CLK_DIV - 1));
  assign rise_stb = half_end && !sclk;
  assign fall_stb = half_end && sclk;

  // NOTE: rst is synchronous here: it is only acted on at a rising sysclk edge,
  // so it appears in the body of the clocked block, not in the sensitivity list.
  always_ff @(posedge sysclk) begin
    if (rst || !run) begin
      // NOTE: clocked state is updated with non-blocking <= so every flop in the
      // design samples pre-edge values regardless of statement order.
      half_cnt <= '0;
      sclk     <= 1'b0;
    end else if (half_end) begin
      half_cnt <= '0;
      sclk     <= ~sclk;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: accepts one FRAME_W-bit frame per request, shifts it out
// MSB first while capturing miso, then enforces a cs-high gap before the next frame.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int FRAME_W = MASTER_FRAME_WIDTH,
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int CS_IDLE = 4
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               tx_enb,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic               miso,
  output logic               cs,
  output logic               sclk,
  output logic               mosi,
  output logic               busy,
  output logic [FRAME_W-1:0] o_rx_frame,
  output logic               rx_dv
);

  localparam int PH_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  state_t               state, next_state;
  logic [PH_W-1:0]      ph_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 last_rise;
  logic [FRAME_W-1:0]   tx_sr, rx_sr;
  logic                 rise_stb, fall_stb;
  logic                 accept;
  logic                 hold_done;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .sysclk   (sysclk),
    .rst      (rst),
    .run      (state == ST_XFER),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign mosi = tx_sr[FRAME_W-1];

  always_ff @(posedge sysclk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    // NOTE: every always_comb output is given a default first so that no path
    // through the case leaves it unassigned, which would infer a latch.
    next_state = state;
    accept     = 1'b0;
    hold_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = tx_enb;
        if (tx_enb) next_state = ST_SETUP;
      end
      ST_SETUP: if (ph_cnt == PH_W'(CLK_DIV - 1)) next_state = ST_XFER;
      // The falling edge after the final rise ends the frame instead of shifting.
      ST_XFER:  if (fall_stb && last_rise) next_state = ST_HOLD;
      ST_HOLD: begin
        hold_done = (ph_cnt == PH_W'(CLK_DIV - 1));
        if (hold_done) next_state = ST_GAP;
      end
      ST_GAP:   if (ph_cnt == PH_W'(CS_IDLE - 1)) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      ph_cnt     <= '0;
      bit_cnt    <= '0;
      last_rise  <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      cs         <= 1'b1;
      busy       <= 1'b0;
      rx_dv      <= 1'b0;
      o_rx_frame <= '0;
    end else begin
      if (next_state != state || state == ST_IDLE || state == ST_XFER) ph_cnt <= '0;
      else                                                             ph_cnt <= ph_cnt + 1'b1;

      cs    <= !(next_state inside {ST_SETUP, ST_XFER, ST_HOLD});
      busy  <= (next_state != ST_IDLE);
      rx_dv <= 1'b0;

      if (accept) begin
        tx_sr     <= i_frame;
        rx_sr     <= '0;
        bit_cnt   <= '0;
        last_rise <= 1'b0;
      end

      if (state == ST_XFER) begin
        if (rise_stb) begin
          rx_sr <= {rx_sr[FRAME_W-2:0], miso};
          // Saturating count: the FRAME_W-th rise only arms the end-of-frame flag.
          if (bit_cnt == BIT_CNT_W'(FRAME_W - 1)) last_rise <= 1'b1;
          else                                    bit_cnt   <= bit_cnt + 1'b1;
        end
        if (fall_stb && !last_rise) tx_sr <= tx_sr << 1;
      end

      if (hold_done) begin
        o_rx_frame <= rx_sr;
        rx_dv      <= 1'b1;
        tx_sr      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: vector table of single frames (loopback and
// a behavioural slave), then back-to-back, mid-transfer reset and CLK_DIV sweeps.
module tb_spi_master_ctrl;
  import spi_master_ctrl_pkg::*;

  localparam int W = 24;

  logic         sysclk = 1'b0;
  logic         rst    = 1'b1;
  logic         tx_enb = 1'b0;
  logic         sw_tx  = 1'b0;
  logic [W-1:0] i_frame = '0;
  logic         miso;
  logic         cs, sclk, mosi, busy, rx_dv;
  logic [W-1:0] o_rx_frame;

  logic [1:0]   sw_cs, sw_sclk, sw_mosi, sw_busy, sw_dvs;
  logic [W-1:0] sw_rx [2];

  logic         use_loop = 1'b1;
  logic [W-1:0] slv_tx = '0, slv_sr = '0, slv_rx = '0;

  always #5 sysclk = ~sysclk;

  assign miso = use_loop ? mosi : slv_sr[W-1];

  spi_master_ctrl #(.FRAME_W(W), .CLK_DIV(2), .CS_IDLE(4)) dut (
    .sysclk(sysclk), .rst(rst), .tx_enb(tx_enb), .i_frame(i_frame), .miso(miso),
    .cs(cs), .sclk(sclk), .mosi(mosi), .busy(busy), .o_rx_frame(o_rx_frame), .rx_dv(rx_dv)
  );

  spi_master_ctrl #(.FRAME_W(W), .CLK_DIV(1), .CS_IDLE(4)) dut_div1 (
    .sysclk(sysclk), .rst(rst), .tx_enb(sw_tx), .i_frame(i_frame), .miso(1'b1),
    .cs(sw_cs[0]), .sclk(sw_sclk[0]), .mosi(sw_mosi[0]), .busy(sw_busy[0]),
    .o_rx_frame(sw_rx[0]), .rx_dv(sw_dvs[0])
  );

  spi_master_ctrl #(.FRAME_W(W), .CLK_DIV(5), .CS_IDLE(4)) dut_div5 (
    .sysclk(sysclk), .rst(rst), .tx_enb(sw_tx), .i_frame(i_frame), .miso(1'b1),
    .cs(sw_cs[1]), .sclk(sw_sclk[1]), .mosi(sw_mosi[1]), .busy(sw_busy[1]),
    .o_rx_frame(sw_rx[1]), .rx_dv(sw_dvs[1])
  );

  // Monitor and slave model, all in one process sampling pre-edge values.
  int   cyc = 0, cs_low_total = 0, dv_total = 0, rise_total = 0, hi_run = 0, last_gap = 0;
  logic sclk_q = 1'b0, cs_q = 1'b1;
  int   sw_low [2] = '{0, 0};
  int   sw_dv  [2] = '{0, 0};
  int   sw_last[2] = '{-1, -1};
  int   sw_pmin[2] = '{999, 999};
  int   sw_pmax[2] = '{0, 0};
  logic [1:0] sw_sclk_q = '0, sw_cs_q = '1;

  always @(posedge sysclk) begin
    cyc++;
    if (cs === 1'b0) cs_low_total++;
    if (rx_dv === 1'b1) dv_total++;
    if (cs === 1'b1) hi_run++;
    else begin
      if (hi_run > 0) last_gap = hi_run;
      hi_run = 0;
    end
    if (cs_q === 1'b1 && cs === 1'b0) slv_sr = slv_tx;
    if (sclk === 1'b1 && sclk_q === 1'b0) begin
      rise_total++;
      slv_rx = {slv_rx[W-2:0], mosi};
    end
    if (sclk === 1'b0 && sclk_q === 1'b1) slv_sr = slv_sr << 1;
    sclk_q = sclk;
    cs_q   = cs;
    for (int i = 0; i < 2; i++) begin
      if (sw_cs_q[i] === 1'b1 && sw_cs[i] === 1'b0) begin
        sw_last[i] = -1; sw_pmin[i] = 999; sw_pmax[i] = 0;
      end
      if (sw_cs[i] === 1'b0) sw_low[i]++;
      if (sw_dvs[i] === 1'b1) sw_dv[i]++;
      if (sw_sclk[i] === 1'b1 && sw_sclk_q[i] === 1'b0) begin
        if (sw_last[i] >= 0) begin
          if (cyc - sw_last[i] < sw_pmin[i]) sw_pmin[i] = cyc - sw_last[i];
          if (cyc - sw_last[i] > sw_pmax[i]) sw_pmax[i] = cyc - sw_last[i];
        end
        sw_last[i] = cyc;
      end
    end
    sw_sclk_q = sw_sclk;
    sw_cs_q   = sw_cs;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int t = 0;
    while (busy !== lvl && t < 2000) begin tick(); t++; end
    check({tag, " busy level"}, 32'(busy), 32'(lvl));
  endtask

  task automatic wait_dv(input string tag);
    int t = 0;
    while (rx_dv !== 1'b1 && t < 2000) begin tick(); t++; end
    check({tag, " rx_dv seen"}, 32'(rx_dv), 32'd1);
  endtask

  task automatic run_xfer(input logic [W-1:0] f, input string tag,
                          output int d_low, output int d_dv, output int d_rise);
    int b_low, b_dv, b_rise;
    tick();
    b_low = cs_low_total; b_dv = dv_total; b_rise = rise_total;
    i_frame = f;
    tx_enb  = 1'b1;
    tick();
    tx_enb  = 1'b0;
    i_frame = ~f;
    wait_busy(1'b0, tag);
    d_low  = cs_low_total - b_low;
    d_dv   = dv_total - b_dv;
    d_rise = rise_total - b_rise;
  endtask

  typedef struct {
    logic [W-1:0] frame;
    logic         loop;
    logic [W-1:0] slv_tx;
    logic [W-1:0] exp_rx;
    logic [W-1:0] exp_slv;
  } vec_t;

  vec_t         vecs[6];
  logic [W-1:0] fr[4];

  initial begin
    int d_low, d_dv, d_rise, b_dv, b_low[2], b_swdv[2], t;
    string tag;

    vecs[0] = '{24'h81A1D1, 1'b1, 24'h000000, 24'h81A1D1, 24'h81A1D1};
    vecs[1] = '{24'h000001, 1'b1, 24'h000000, 24'h000001, 24'h000001};
    vecs[2] = '{{CMD_LED_SET, 8'h02, 8'h0A}, 1'b0, 24'h000000, 24'h000000, 24'h10020A};
    vecs[3] = '{{CMD_LED_SET, 8'h09, 8'h05}, 1'b0, 24'h00000A, 24'h00000A, 24'h100905};
    vecs[4] = '{24'h7E0055, 1'b0, 24'hA5C33C, 24'hA5C33C, 24'h7E0055};
    vecs[5] = '{24'hFFFFFF, 1'b1, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};
    fr = '{24'h3C5A96, 24'h0F0F0F, 24'hC0FFEE, 24'hDEAD00};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset cs", 32'(cs), 32'd1);
    check("reset sclk", 32'(sclk), 32'd0);
    check("reset mosi", 32'(mosi), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rx_dv", 32'(rx_dv), 32'd0);
    check("reset o_rx_frame", 32'(o_rx_frame), 32'd0);

    // Single-frame vectors: cs low 2 + 24*4 + 2 = 100 cycles at CLK_DIV=2.
    for (int i = 0; i < 6; i++) begin
      tag      = $sformatf("vec%0d", i);
      use_loop = vecs[i].loop;
      slv_tx   = vecs[i].slv_tx;
      run_xfer(vecs[i].frame, tag, d_low, d_dv, d_rise);
      check({tag, " o_rx_frame"}, 32'(o_rx_frame), 32'(vecs[i].exp_rx));
      check({tag, " slave rx"}, 32'(slv_rx), 32'(vecs[i].exp_slv));
      check({tag, " rx_dv count"}, 32'(d_dv), 32'd1);
      check({tag, " cs low cycles"}, 32'(d_low), 32'd100);
      check({tag, " sclk rises"}, 32'(d_rise), 32'd24);
      check({tag, " idle cs"}, 32'(cs), 32'd1);
      check({tag, " idle mosi"}, 32'(mosi), 32'd0);
    end

    // Request held high for three frames, i_frame changed during each transfer.
    use_loop = 1'b1;
    b_dv = dv_total;
    tick();
    i_frame = fr[0];
    tx_enb  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tag = $sformatf("b2b%0d", k);
      wait_busy(1'b1, tag);
      if (k < 2) i_frame = fr[k+1];
      else begin
        tx_enb  = 1'b0;
        i_frame = fr[3];
      end
      wait_dv(tag);
      check({tag, " o_rx_frame"}, 32'(o_rx_frame), 32'(fr[k]));
      // GAP is 4 cycles, plus the IDLE cycle that accepts the next request.
      if (k > 0) check({tag, " cs high gap"}, 32'(last_gap), 32'd5);
      wait_busy(1'b0, tag);
    end
    repeat (10) tick();
    check("b2b no extra frame", 32'(busy), 32'd0);
    check("b2b rx_dv count", 32'(dv_total - b_dv), 32'd3);
    i_frame = 24'h123456;
    repeat (5) tick();
    check("rx hold", 32'(o_rx_frame), 32'(fr[2]));

    // Reset on the 10th sclk rise, with a simultaneous request that must be ignored.
    b_dv = dv_total;
    d_rise = rise_total;
    i_frame = 24'h81A1D1;
    tx_enb  = 1'b1;
    tick();
    tx_enb = 1'b0;
    t = 0;
    while (rise_total - d_rise < 10 && t < 500) begin tick(); t++; end
    check("rst: 10 rises reached", 32'(rise_total - d_rise), 32'd10);
    rst    = 1'b1;
    tx_enb = 1'b1;
    tick();
    rst    = 1'b0;
    tx_enb = 1'b0;
    check("rst: cs", 32'(cs), 32'd1);
    check("rst: sclk", 32'(sclk), 32'd0);
    check("rst: busy", 32'(busy), 32'd0);
    check("rst: mosi", 32'(mosi), 32'd0);
    check("rst: o_rx_frame", 32'(o_rx_frame), 32'd0);
    repeat (8) tick();
    check("rst: request ignored", 32'(busy), 32'd0);
    check("rst: no rx_dv", 32'(dv_total - b_dv), 32'd0);
    run_xfer(24'h81A1D1, "post-rst", d_low, d_dv, d_rise);
    check("post-rst o_rx_frame", 32'(o_rx_frame), 32'h0081A1D1);
    check("post-rst rx_dv count", 32'(d_dv), 32'd1);
    check("post-rst cs low cycles", 32'(d_low), 32'd100);

    // CLK_DIV sweep, miso tied high: cs low 50*CLK_DIV, sclk period 2*CLK_DIV.
    tick();
    for (int i = 0; i < 2; i++) begin b_low[i] = sw_low[i]; b_swdv[i] = sw_dv[i]; end
    i_frame = 24'h5A5A5A;
    sw_tx   = 1'b1;
    tick();
    sw_tx = 1'b0;
    t = 0;
    while (sw_busy !== 2'b00 && t < 3000) begin tick(); t++; end
    check("sweep done", 32'(sw_busy), 32'd0);
    check("div1 o_rx_frame", 32'(sw_rx[0]), 32'h00FFFFFF);
    check("div5 o_rx_frame", 32'(sw_rx[1]), 32'h00FFFFFF);
    check("div1 cs low cycles", 32'(sw_low[0] - b_low[0]), 32'd50);
    check("div5 cs low cycles", 32'(sw_low[1] - b_low[1]), 32'd250);
    check("div1 rx_dv count", 32'(sw_dv[0] - b_swdv[0]), 32'd1);
    check("div5 rx_dv count", 32'(sw_dv[1] - b_swdv[1]), 32'd1);
    check("div1 min period", 32'(sw_pmin[0]), 32'd2);
    check("div1 max period", 32'(sw_pmax[0]), 32'd2);
    check("div5 min period", 32'(sw_pmin[1]), 32'd10);
    check("div5 max period", 32'(sw_pmax[1]), 32'd10);
    check("sweep idle mosi", 32'(sw_mosi), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
